// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the instruction path: loader FSM state encoding,
// address / instruction widths, and the instruction field positions that
// both the program loader (writer) and the decode logic (reader) agree on.
//
// Instruction word layout (24 bits, big-endian byte order in the stream):
//   [23:20] opcode  [19:16] rs  [15:12] rt  [11:8] rd  [7:0] shamp
package cpu_pkg;

    localparam int ADDR_W         = 8;
    localparam int INSTR_W        = 24;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 3;

    // Field positions, shared with decode.
    localparam int OPC_MSB   = 23;
    localparam int OPC_LSB   = 20;
    localparam int RS_MSB    = 19;
    localparam int RS_LSB    = 16;
    localparam int RT_MSB    = 15;
    localparam int RT_LSB    = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 8;
    localparam int SHAMP_MSB = 7;
    localparam int SHAMP_LSB = 0;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_RECV  = 3'd1,
        LD_WRITE = 3'd2,
        LD_DONE  = 3'd3,
        LD_ERR   = 3'd4
    } ld_state_t;

    // First byte received lands in the most significant position.
    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [BYTE_W-1:0] b0,
        input logic [BYTE_W-1:0] b1,
        input logic [BYTE_W-1:0] b2
    );
        return {b0, b1, b2};
    endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer
// Collects accepted stream bytes into 24-bit instruction words.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         restart packing at byte 0 (new load session)
//   accept        a byte handshake happens this cycle
//   byte_in       stream byte
//   last_in       byte_in is the final byte of the program
//   word_done     combinational: this handshake completes a word (byte 2)
//   partial_last  combinational: this handshake ends the program mid-word
//   word_ready    registered one-cycle pulse, the cycle after word_done
//   word_last     the most recently completed word carried last_in
//   word          most recently completed word; held until the next one
module byte_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [BYTE_W-1:0]  byte_in,
    input  logic               last_in,
    output logic               word_done,
    output logic               partial_last,
    output logic               word_ready,
    output logic               word_last,
    output logic [INSTR_W-1:0] word
);

    logic [1:0]                    idx_reg;
    logic [1:0][BYTE_W-1:0]        lane_bytes;
    logic [INSTR_W-1:0]            word_reg;
    logic                          word_ready_reg;
    logic                          word_last_reg;

    assign word_done    = accept && (idx_reg == 2'd2);
    assign partial_last = accept && last_in && (idx_reg != 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= 2'd0;
        end else if (clear) begin
            idx_reg <= 2'd0;
        end else if (accept) begin
            idx_reg <= (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
        end
    end

    // Bytes 0 and 1 are parked in their own lanes; byte 2 is taken straight
    // from the input so the word is assembled on the completing handshake.
    for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
        logic [BYTE_W-1:0] lane_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_reg <= '0;
            end else if (accept && (idx_reg == 2'(gi))) begin
                lane_reg <= byte_in;
            end
        end

        assign lane_bytes[gi] = lane_reg;
    end

    // The assembled word lives in its own register so that the RAM write
    // data stays put while the next word's bytes arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg       <= '0;
            word_ready_reg <= 1'b0;
            word_last_reg  <= 1'b0;
        end else begin
            word_ready_reg <= word_done;
            if (clear) begin
                word_last_reg <= 1'b0;
            end
            if (word_done) begin
                word_reg      <= pack_instr(lane_bytes[0], lane_bytes[1], byte_in);
                word_last_reg <= last_in;
            end
        end
    end

    assign word       = word_reg;
    assign word_ready = word_ready_reg;
    assign word_last  = word_last_reg;

endmodule

// File: rtl/program_loader.sv
// program_loader
// Receives a program as a byte stream (valid/ready), packs every three bytes
// into a 24-bit instruction and writes it to instruction RAM at consecutive
// addresses from 0. The CPU is held in reset until a whole program is in.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle pulse: begin a load session (IDLE/DONE/ERR only)
//   byte_in      stream byte;  byte_valid / byte_ready handshake
//   byte_last    byte_in is the final byte of the program
//   mem_we       RAM write strobe, one cycle per word
//   mem_addr     RAM write address (wraps at 2**ADDR_W)
//   mem_wdata    instruction word being written
//   cpu_hold     keep the CPU in reset while high (low only in DONE)
//   done, error  session outcome levels
//   word_count   words written in this session (0..MAX_WORDS)
//
// DATA_W must equal 24 and MAX_WORDS must equal 2**ADDR_W; they are not
// meant to be overridden.
module program_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 24,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              byte_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    import cpu_pkg::*;

    // word_count value seen in WRITE when the word being written is the
    // last one that fits.
    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(MAX_WORDS - 1);

    ld_state_t         state_reg;
    ld_state_t         state_next;
    logic              clear_session;
    logic              accept;

    logic [ADDR_W-1:0] mem_addr_reg;
    logic [ADDR_W:0]   word_count_reg;

    logic              word_done;
    logic              partial_last;
    logic              word_ready;
    logic              word_last;
    logic [INSTR_W-1:0] word;

    // byte_ready is decoded purely from the state register, so it never
    // depends combinationally on byte_valid.
    assign accept = byte_valid && byte_ready;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear_session),
        .accept       (accept),
        .byte_in      (byte_in),
        .last_in      (byte_last),
        .word_done    (word_done),
        .partial_last (partial_last),
        .word_ready   (word_ready),
        .word_last    (word_last),
        .word         (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LD_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clear_session = 1'b0;
        byte_ready    = 1'b0;
        mem_we        = 1'b0;
        cpu_hold      = 1'b1;
        done          = 1'b0;
        error         = 1'b0;

        case (state_reg)
            LD_IDLE: begin
                if (start) begin
                    state_next    = LD_RECV;
                    clear_session = 1'b1;
                end
            end
            LD_RECV: begin
                byte_ready = 1'b1;
                if (word_done) begin
                    state_next = LD_WRITE;
                end else if (partial_last) begin
                    state_next = LD_ERR;
                end
            end
            LD_WRITE: begin
                mem_we = word_ready;
                if (word_last) begin
                    state_next = LD_DONE;
                end else if (word_count_reg == LAST_COUNT) begin
                    state_next = LD_ERR;
                end else begin
                    state_next = LD_RECV;
                end
            end
            LD_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    state_next    = LD_RECV;
                    clear_session = 1'b1;
                end
            end
            LD_ERR: begin
                error = 1'b1;
                if (start) begin
                    state_next    = LD_RECV;
                    clear_session = 1'b1;
                end
            end
            default: begin
                state_next = LD_IDLE;
            end
        endcase
    end

    // Address and count advance after the write cycle, so mem_addr is
    // stable for the whole of WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_reg   <= '0;
            word_count_reg <= '0;
        end else if (clear_session) begin
            mem_addr_reg   <= '0;
            word_count_reg <= '0;
        end else if (state_reg == LD_WRITE) begin
            mem_addr_reg   <= mem_addr_reg + 1'b1;
            word_count_reg <= word_count_reg + 1'b1;
        end
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = DATA_W'(word);
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard: stimulus pushes
// the expected {addr, data} of each RAM write; a monitor compares every
// mem_we cycle against the head of the queue.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        byte_last = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Monitor: one line per RAM write.
    always @(negedge clk) begin
        if (mem_we) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            check("ready_low_in_write", 32'(byte_ready), 32'd0);
            if (exp_q.size() != 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=0x%06h (expected addr=%0d data=0x%06h)",
                         mem_addr, mem_wdata, e[31:24], e[23:0]);
                check("write_addr", 32'(mem_addr), 32'(e[31:24]));
                check("write_data", 32'(mem_wdata), 32'(e[23:0]));
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int budget;
        repeat (gap) begin @(posedge clk); #1; end
        byte_in = b; byte_last = last; byte_valid = 1'b1;
        budget = 0;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            budget++;
            if (budget > 50) break;
        end
        if (budget > 50) begin
            check("byte_accept_timeout", 32'(budget), 32'd0);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0; byte_last = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic last, input int max_gap);
        send_byte(a, 1'b0, $urandom_range(0, max_gap));
        send_byte(b, 1'b0, $urandom_range(0, max_gap));
        send_byte(c, last, $urandom_range(0, max_gap));
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 3000) begin @(negedge clk); n++; end
        check("end_wait_timeout", 32'(n < 3000), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic h, input logic [8:0] wc);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        check({tag, "_word_count"}, 32'(word_count), 32'(wc));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        logic [7:0] b0, b1, b2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_ready", 32'(byte_ready), 32'd0);

        // 1-word program
        pulse_start();
        exp_q.push_back({8'd0, 24'h1A2B3C});
        send_word(8'h1A, 8'h2B, 8'h3C, 1'b1, 0);
        wait_end();
        check_status("one_word", 1'b1, 1'b0, 1'b0, 9'd1);

        // Reload after DONE: 3 words with gaps; start pulse inside RECV ignored
        pulse_start();
        @(negedge clk);
        check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
        check("reload_done_cleared", 32'(done), 32'd0);
        check("reload_ready", 32'(byte_ready), 32'd1);
        check("reload_count_cleared", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        exp_q.push_back({8'd0, 24'h010203});
        exp_q.push_back({8'd1, 24'hA0B0C0});
        exp_q.push_back({8'd2, 24'hFFEE11});
        send_word(8'h01, 8'h02, 8'h03, 1'b0, 3);
        send_byte(8'hA0, 1'b0, $urandom_range(0, 3));
        pulse_start();
        send_byte(8'hB0, 1'b0, $urandom_range(0, 3));
        send_byte(8'hC0, 1'b0, $urandom_range(0, 3));
        send_word(8'hFF, 8'hEE, 8'h11, 1'b1, 3);
        wait_end();
        check_status("three_words", 1'b1, 1'b0, 1'b0, 9'd3);

        // Partial last word -> error
        pulse_start();
        exp_q.push_back({8'd0, 24'hC0FFEE});
        send_word(8'hC0, 8'hFF, 8'hEE, 1'b0, 1);
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b1, 0);
        wait_end();
        check_status("partial", 1'b0, 1'b1, 1'b1, 9'd1);
        pulse_start();
        @(negedge clk);
        check("restart_ready", 32'(byte_ready), 32'd1);
        check("restart_count", 32'(word_count), 32'd0);
        check("restart_error_cleared", 32'(error), 32'd0);
        @(posedge clk); #1;

        // Async reset after 4 bytes
        exp_q.push_back({8'd0, 24'h112233});
        send_word(8'h11, 8'h22, 8'h33, 1'b0, 0);
        send_byte(8'h44, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        exp_q.push_back({8'd0, 24'h556677});
        send_word(8'h55, 8'h66, 8'h77, 1'b1, 0);
        wait_end();
        check_status("after_rst", 1'b1, 1'b0, 1'b0, 9'd1);

        // Overflow: 768 bytes, no last
        pulse_start();
        for (int w = 0; w < 256; w++) begin
            b0 = 8'(3 * w); b1 = 8'(3 * w + 1); b2 = 8'(3 * w + 2);
            exp_q.push_back({8'(w), b0, b1, b2});
            send_word(b0, b1, b2, 1'b0, 0);
        end
        wait_end();
        check_status("overflow", 1'b0, 1'b1, 1'b1, 9'd256);
        // Offer more bytes: none may be accepted or written.
        byte_in = 8'hAA; byte_valid = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("overflow_no_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b0;
        @(posedge clk); #1;

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
